// File: rtl/mem_access_unit.sv
// MEM stage: issues aligned loads/stores, waits for ack, and formats load data for writeback.
// Define MEM_ACCESS_TIMEOUT_EN to enable the ack watchdog (ABORT state, bus_error_o).
module mem_access_unit #(
    parameter int NB_DATA        = 32,
    parameter int N_REG_ADDR     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [5:0]            mem_signals_i,
    input  logic [2:0]            wb_signals_i,
    input  logic [NB_DATA-1:0]    alu_result_i,
    input  logic [NB_DATA-1:0]    store_data_i,
    input  logic [N_REG_ADDR-1:0] rd_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [NB_DATA-1:0]    mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [NB_DATA-1:0]    mem_wdata_o,
    input  logic [NB_DATA-1:0]    mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [2:0]            wb_signals_o,
    output logic [NB_DATA-1:0]    wb_data_o,
    output logic [NB_DATA-1:0]    alu_result_o,
    output logic [N_REG_ADDR-1:0] rd_o,
    output logic                  misalign_o,
    output logic                  bus_error_o
);

`ifdef MEM_ACCESS_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ABORT = 2'd2} state_t;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1} state_t;
`endif

    state_t state;

    logic                  is_read, is_write, is_mem, size_ok, misalign, start;
    logic [2:0]            size;
    logic [3:0]            be_next;
    logic [NB_DATA-1:0]    wdata_next;
    logic [NB_DATA-1:0]    shifted, load_data;

    // Pending instruction captured when an access starts.
    logic                  p_sign, p_read;
    logic [2:0]            p_size;
    logic [1:0]            p_off;
    logic [NB_DATA-1:0]    p_alu;
    logic [2:0]            p_wb;
    logic [N_REG_ADDR-1:0] p_rd;

    always_comb begin
        is_read  = mem_signals_i[4];
        is_write = mem_signals_i[3];
        size     = mem_signals_i[2:0];
        is_mem   = is_read | is_write;
        size_ok  = (size == 3'b001) || (size == 3'b010) || (size == 3'b100);
        misalign = is_mem && ((is_read && is_write) || !size_ok ||
                              (size[1] && alu_result_i[0]) ||
                              (size[2] && (alu_result_i[1:0] != 2'b00)));
        start    = (state == IDLE) && valid_i && is_mem && !misalign;
        stall_o  = start || ((state == ACCESS) && !mem_ack_i);
    end

    // Little-endian lane placement: enables select the lanes, data is replicated across all.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data_i;
        if (size[0]) begin
            be_next    = 4'b0001 << alu_result_i[1:0];
            wdata_next = {(NB_DATA/8){store_data_i[7:0]}};
        end else if (size[1]) begin
            be_next    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            wdata_next = {(NB_DATA/16){store_data_i[15:0]}};
        end
    end

    always_comb begin
        shifted   = mem_rdata_i >> {p_off, 3'b000};
        load_data = shifted;
        if (p_size[0])
            load_data = {{(NB_DATA-8){p_sign & shifted[7]}}, shifted[7:0]};
        else if (p_size[1])
            load_data = {{(NB_DATA-16){p_sign & shifted[15]}}, shifted[15:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
            wb_valid_o   <= 1'b0;
            wb_signals_o <= '0;
            wb_data_o    <= '0;
            alu_result_o <= '0;
            rd_o         <= '0;
            misalign_o   <= 1'b0;
            bus_error_o  <= 1'b0;
            p_sign       <= 1'b0;
            p_read       <= 1'b0;
            p_size       <= '0;
            p_off        <= '0;
            p_alu        <= '0;
            p_wb         <= '0;
            p_rd         <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            wb_valid_o  <= 1'b0;
            misalign_o  <= 1'b0;
            bus_error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ACCESS;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= is_write;
                        mem_addr_o  <= {alu_result_i[NB_DATA-1:2], 2'b00};
                        mem_be_o    <= be_next;
                        mem_wdata_o <= wdata_next;
                        p_sign      <= mem_signals_i[5];
                        p_read      <= is_read;
                        p_size      <= size;
                        p_off       <= alu_result_i[1:0];
                        p_alu       <= alu_result_i;
                        p_wb        <= wb_signals_i;
                        p_rd        <= rd_i;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end else if (valid_i) begin
                        // Non-memory or rejected memory op: emit the slot directly.
                        wb_valid_o   <= 1'b1;
                        wb_signals_o <= {wb_signals_i[2] & ~misalign, wb_signals_i[1:0]};
                        wb_data_o    <= alu_result_i;
                        alu_result_o <= alu_result_i;
                        rd_o         <= rd_i;
                        misalign_o   <= misalign;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        state        <= IDLE;
                        mem_req_o    <= 1'b0;
                        mem_we_o     <= 1'b0;
                        wb_valid_o   <= 1'b1;
                        wb_signals_o <= p_wb;
                        wb_data_o    <= p_read ? load_data : p_alu;
                        alu_result_o <= p_alu;
                        rd_o         <= p_rd;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        state        <= ABORT;
                        mem_req_o    <= 1'b0;
                        mem_we_o     <= 1'b0;
                        bus_error_o  <= 1'b1;
                        wb_valid_o   <= 1'b1;
                        wb_signals_o <= {1'b0, p_wb[1:0]};
                        wb_data_o    <= p_alu;
                        alu_result_o <= p_alu;
                        rd_o         <= p_rd;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
`else
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
